// File: rtl/pdh_gpio_tx.sv
// pdh_gpio_tx: captures a burst of ADC samples into a local buffer, then hands them
// to the PS one word at a time over a toggle request/acknowledge GPIO handshake.
// Build option: define PDH_TX_TIMEOUT_EN to enable the ack timeout (timeout_o);
// otherwise WAIT_ACK waits forever and timeout_o is tied low.
module pdh_gpio_tx #(
    parameter int unsigned DATA_WIDTH     = 28,
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned TIMEOUT_CYCLES = 125000000,
    localparam int unsigned ADDR_W        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic                  sample_valid_i,
    input  logic                  cap_start_i,
    input  logic [ADDR_W:0]       cap_len_i,
    input  logic                  abort_i,
    input  logic                  ps_ack_i,
    output logic [31:0]           axi_to_ps_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {StIdle, StCapture, StSend, StWaitAck} state_e;

    localparam logic [ADDR_W:0] IdxOne   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] DepthLen = {1'b1, {ADDR_W{1'b0}}};

    state_e                state_q, state_d;
    logic [ADDR_W:0]       len_q, len_d;
    logic [ADDR_W:0]       wr_idx_q, wr_idx_d;
    logic [ADDR_W:0]       rd_idx_q, rd_idx_d;
    logic [ADDR_W:0]       rd_idx_inc;
    logic                  rd_vld_q, rd_vld_d;
    logic [31:0]           out_q, out_d;
    logic [1:0]            frame_q, frame_d;
    logic                  done_q, done_d;
    logic                  ack_meta_q, ack_s_q;
    logic                  acked, last;
    logic                  we, re;
    logic [ADDR_W-1:0]     rd_addr;
    logic [27:0]           payload;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

`ifdef PDH_TX_TIMEOUT_EN
    localparam logic [31:0] TmoLast = TIMEOUT_CYCLES - 1;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_q, timeout_d;
`endif

    assign rd_idx_inc = rd_idx_q + IdxOne;
    assign acked      = (ack_s_q == out_q[31]);
    assign last       = (rd_idx_inc == len_q);

    // Zero-extend the stored sample into the 28-bit payload field.
    always_comb begin
        payload                 = '0;
        payload[DATA_WIDTH-1:0] = rd_data_q;
    end

    // Two-flop synchronizer for the asynchronous PS acknowledge toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= ps_ack_i;
            ack_s_q    <= ack_meta_q;
        end
    end

    // Capture buffer: written only in CAPTURE, read only while draining; not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx_q[ADDR_W-1:0]] <= sample_i;
        end
        if (re) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    // Next-state, buffer control and output word assembly.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        rd_vld_d = rd_vld_q;
        out_d    = out_q;
        frame_d  = frame_q;
        done_d   = 1'b0;
        we       = 1'b0;
        re       = 1'b0;
        rd_addr  = rd_idx_q[ADDR_W-1:0];
`ifdef PDH_TX_TIMEOUT_EN
        timeout_d = timeout_q;
        tmo_cnt_d = '0;
`endif
        if (abort_i) begin
            state_d  = StIdle;
            rd_vld_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cap_start_i && (cap_len_i != '0)) begin
                        state_d  = StCapture;
                        len_d    = (cap_len_i > DepthLen) ? DepthLen : cap_len_i;
                        wr_idx_d = '0;
                        rd_idx_d = '0;
                        rd_vld_d = 1'b0;
`ifdef PDH_TX_TIMEOUT_EN
                        timeout_d = 1'b0;
`endif
                    end
                end
                StCapture: begin
                    if (sample_valid_i) begin
                        we       = 1'b1;
                        wr_idx_d = wr_idx_q + IdxOne;
                        if (wr_idx_q + IdxOne == len_q) begin
                            state_d  = StSend;
                            rd_idx_d = '0;
                            rd_vld_d = 1'b0;
                        end
                    end
                end
                StSend: begin
                    // First word of a frame has no prefetched read; issue it here.
                    if (!rd_vld_q) begin
                        re       = 1'b1;
                        rd_vld_d = 1'b1;
                    end else begin
                        out_d    = {~out_q[31], last, frame_q, payload};
                        rd_vld_d = 1'b0;
                        state_d  = StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (acked) begin
                        if (last) begin
                            done_d  = 1'b1;
                            frame_d = frame_q + 2'd1;
                            state_d = StIdle;
                        end else begin
                            // Prefetch the next word so SEND can publish it on the next edge.
                            rd_idx_d = rd_idx_inc;
                            rd_addr  = rd_idx_inc[ADDR_W-1:0];
                            re       = 1'b1;
                            rd_vld_d = 1'b1;
                            state_d  = StSend;
                        end
                    end
`ifdef PDH_TX_TIMEOUT_EN
                    else if (tmo_cnt_q == TmoLast) begin
                        timeout_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 32'd1;
                    end
`endif
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Control and output state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            len_q    <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            rd_vld_q <= 1'b0;
            out_q    <= '0;
            frame_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            rd_vld_q <= rd_vld_d;
            out_q    <= out_d;
            frame_q  <= frame_d;
            done_q   <= done_d;
        end
    end

`ifdef PDH_TX_TIMEOUT_EN
    // Ack timeout counter and sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign axi_to_ps_o = out_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;

endmodule
